// File: rtl/sc_jug1_position_register_pkg.sv
// Shared definitions for the player-1 state machine and its position register datapath.
package sc_jug1_position_register_pkg;

  localparam logic [1:0] SHIFT_LOAD  = 2'b00;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;
  localparam logic [1:0] SHIFT_HOLD  = 2'b11;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_INIT_POS = 3;
  localparam int MOVECOUNT_W      = 8;

endpackage

// File: rtl/sc_jug1_onehot_encoder.sv
// Turns a one-hot column vector into its binary index; valid is high only when exactly one bit is set.
module sc_jug1_onehot_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] position,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  logic seenBit;
  logic multiBit;

  always_comb begin
    index    = '0;
    seenBit  = 1'b0;
    multiBit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (position[k]) begin
        if (seenBit) multiBit = 1'b1;
        seenBit = 1'b1;
        index   = IDX_W'(k);
      end
    end
    valid = seenBit & ~multiBit;
  end

endmodule

// File: rtl/sc_jug1_position_register.sv
// Player-1 one-hot board position with saturating left/right shifts and edge flags.
// Optional accepted-move counter enabled by defining SC_JUG1_MOVECOUNT_EN.
module sc_jug1_position_register
  import sc_jug1_position_register_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int INIT_POS = DEFAULT_INIT_POS,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic                   SC_STATEMACHINE_JUG1_CLOCK_50,
  input  logic                   SC_STATEMACHINE_JUG1_RESET_InHigh,
  input  logic                   clear_InLow,
  input  logic [1:0]             shiftselection_In,
  output logic [WIDTH-1:0]       position_Out,
  output logic [IDX_W-1:0]       index_Out,
  output logic                   izquierdacomparator_OutLow,
  output logic                   derechacomparator_OutLow,
  output logic                   moved_Out,
  output logic [MOVECOUNT_W-1:0] movecount_Out
);

  localparam logic [WIDTH-1:0] INIT_ONEHOT = {{(WIDTH-1){1'b0}}, 1'b1} << INIT_POS;

  logic [WIDTH-1:0] positionReg;
  logic [WIDTH-1:0] nextPosition;
  logic             positionValid;
  logic             atLeftEdge;
  logic             atRightEdge;

  sc_jug1_onehot_encoder #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W)
  ) onehotEncoder (
    .position(positionReg),
    .index   (index_Out),
    .valid   (positionValid)
  );

  assign atLeftEdge  = positionReg[WIDTH-1];
  assign atRightEdge = positionReg[0];

  // A corrupted (non-one-hot) position outranks every command and snaps back home.
  always_comb begin
    nextPosition = positionReg;
    if (!positionValid || !clear_InLow) begin
      nextPosition = INIT_ONEHOT;
    end else begin
      case (shiftselection_In)
        SHIFT_LOAD:  nextPosition = INIT_ONEHOT;
        SHIFT_LEFT:  if (!atLeftEdge)  nextPosition = positionReg << 1;
        SHIFT_RIGHT: if (!atRightEdge) nextPosition = positionReg >> 1;
        default:     nextPosition = positionReg;
      endcase
    end
  end

  always_ff @(posedge SC_STATEMACHINE_JUG1_CLOCK_50 or posedge SC_STATEMACHINE_JUG1_RESET_InHigh) begin
    if (SC_STATEMACHINE_JUG1_RESET_InHigh) begin
      positionReg <= INIT_ONEHOT;
      moved_Out   <= 1'b0;
    end else begin
      positionReg <= nextPosition;
      moved_Out   <= (nextPosition != positionReg);
    end
  end

  assign position_Out               = positionReg;
  assign izquierdacomparator_OutLow = ~atLeftEdge;
  assign derechacomparator_OutLow   = ~atRightEdge;

`ifdef SC_JUG1_MOVECOUNT_EN
  logic [MOVECOUNT_W-1:0] moveCount;
  logic                   moveAccepted;
  logic                   countClear;

  assign countClear   = !clear_InLow || (shiftselection_In == SHIFT_LOAD);
  assign moveAccepted = positionValid && clear_InLow &&
                        (((shiftselection_In == SHIFT_LEFT)  && !atLeftEdge) ||
                         ((shiftselection_In == SHIFT_RIGHT) && !atRightEdge));

  // Saturates at all-ones so a long game never wraps the statistic.
  always_ff @(posedge SC_STATEMACHINE_JUG1_CLOCK_50 or posedge SC_STATEMACHINE_JUG1_RESET_InHigh) begin
    if (SC_STATEMACHINE_JUG1_RESET_InHigh) begin
      moveCount <= '0;
    end else if (countClear) begin
      moveCount <= '0;
    end else if (moveAccepted && (moveCount != '1)) begin
      moveCount <= moveCount + 1'b1;
    end
  end

  assign movecount_Out = moveCount;
`else
  assign movecount_Out = '0;
`endif

endmodule

// File: doc/sc_jug1_position_register.md
Name: sc_jug1_position_register

Overview:
- Datapath stage directly downstream of the player-1 control state machine. Consumes its active-low clear strobe and 2-bit shift-selection code.
- Holds player 1's one-hot board position and shifts it left or right one column per command.
- Returns active-low edge-comparator flags to the state machine so it can block moves at the board limits.
- Also drives the position to the display/collision logic.

Parameters:
- WIDTH, 8, number of board columns; legal range 2..32.
- INIT_POS, 3, column index loaded on reset and on clear; must be < WIDTH.
- IDX_W, $clog2(WIDTH), width of the binary index output; derived, not overridden.

Ports:
- SC_STATEMACHINE_JUG1_CLOCK_50  in  1  system clock, 50 MHz, rising edge.
- SC_STATEMACHINE_JUG1_RESET_InHigh  in  1  asynchronous, active-high reset.
- clear_InLow  in  1  active-low synchronous reload to INIT_POS.
- shiftselection_In  in  2  move command: 01 = left, 10 = right, 11 = hold, 00 = reload INIT_POS.
- position_Out  out  WIDTH  one-hot position; bit k set means column k.
- index_Out  out  IDX_W  binary column index of position_Out.
- izquierdacomparator_OutLow  out  1  0 when at the leftmost column (bit WIDTH-1), else 1.
- derechacomparator_OutLow  out  1  0 when at the rightmost column (bit 0), else 1.
- moved_Out  out  1  one-cycle pulse, cycle after the position actually changed.
- movecount_Out  out  8  count of accepted moves (see Optional Feature).

Behaviour:
- Reset: the clock is SC_STATEMACHINE_JUG1_CLOCK_50; the reset is SC_STATEMACHINE_JUG1_RESET_InHigh, asynchronous and active-high. While reset is asserted:
  - position = one-hot(INIT_POS); index = INIT_POS.
  - moved_Out = 0; movecount_Out = 0.
  - Comparator flags follow position (both 1 unless INIT_POS sits at an edge).
- Register updates on the rising edge, with this priority:
  - clear_InLow = 0: load one-hot(INIT_POS); shiftselection is ignored.
  - else shiftselection 00: load one-hot(INIT_POS).
  - else 01 (left): shift toward the MSB by one, only if bit WIDTH-1 is clear; otherwise hold.
  - else 10 (right): shift toward the LSB by one, only if bit 0 is clear; otherwise hold.
  - else 11: hold.
- Edge saturation: no wrap-around. A move commanded at an edge is dropped silently, with no moved pulse. This is a second line of defence behind the state machine's comparator check.
- Comparator flags and index_Out are combinational decodes of the registered position, so there are zero cycles from the position update. The state machine sees the updated flags in the same cycle it evaluates its check state.
- moved_Out: registered. It is 1 in the cycle after an edge where the position register changed value.
  - A reload to INIT_POS from a different position counts as a change.
  - A reload to the same position does not.
- Latency: a command sampled on edge N appears on position_Out, index_Out and the flags after edge N. moved_Out is valid on that same cycle.
- One-hot integrity: if position is ever not exactly one-hot (zero or multiple bits set), the next edge forces one-hot(INIT_POS) regardless of inputs. moved_Out pulses.
- Reset mid-operation (asynchronous assertion between edges) immediately returns all outputs to their reset values.
- No internal FSM. The only state is the position register, the moved flag and the optional counter.

Optional Feature:
- Macro SC_JUG1_MOVECOUNT_EN.
- Defined:
  - 8-bit counter increments on every accepted left/right move.
  - Saturates at 255.
  - Cleared to 0 by reset, clear_InLow = 0, or shiftselection 00.
  - Reloads do not increment it.
- Undefined: movecount_Out is tied to 8'd0 and no counter flops are inferred. The port list is identical in both builds.

Decomposition:
- Shared package (also used by the state machine): shift-selection code constants SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10, SHIFT_HOLD=2'b11, SHIFT_LOAD=2'b00.
- Also in the package: default WIDTH/INIT_POS and the movecount width (8).
- One natural sub-module: sc_jug1_onehot_encoder. It is combinational and turns the one-hot position into the binary index plus a valid (exactly-one-hot) bit. The valid bit feeds the integrity recovery.

Test Plan:
All scenarios use WIDTH=8, INIT_POS=3.
1. Assert reset, release, shiftselection=11 -> position_Out=8'b00001000, index_Out=3, both comparators=1, moved_Out=0, movecount_Out=0.
2. Pulse shiftselection=01 for one cycle -> position_Out=8'b00010000, index_Out=4, moved_Out=1 for exactly one cycle; movecount_Out=1 with the macro, 0 without.
3. Hold shiftselection=01 for 6 cycles from column 3 -> position reaches 8'b10000000 after 4 edges, izquierdacomparator_OutLow=0, extra lefts hold with moved_Out=0, movecount_Out=4.
4. From column 7, apply clear_InLow=0 together with shiftselection=10 -> position_Out=8'b00001000, moved_Out=1, movecount_Out=0.
5. Apply shiftselection=10 for 5 cycles from column 3 -> stops at 8'b00000001, derechacomparator_OutLow=0, then assert reset asynchronously mid-cycle -> outputs return to the scenario-1 values before the next edge.
6. Force position to 8'b00000000 via a hierarchical deposit -> next edge gives 8'b00001000 and moved_Out=1.
